dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the MEM stage. It is the far end of the active-low `DmemREB`/`DmemWEB` request interface driven from ID/EX. It holds a word-organised synchronous memory array, inserts a configurable number of wait states, and stalls the pipeline while an access is outstanding. It returns load data with a one-cycle valid strobe and flags illegal requests.

## Interface

**Parameters**
- `ADDR_W`, default 10: word-index width; the array holds 2^ADDR_W 32-bit words.
- `WAIT_CYCLES`, default 2: extra wait states before the array access; legal range 0–15.

**Ports**
- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `DmemREB`  in  1  read request, active low.
- `DmemWEB`  in  1  write request, active low.
- `DmemAddr`  in  32  byte address, taken from the ALU result.
- `DmemWData`  in  32  store data.
- `DmemRData`  out  32  load data, registered.
- `DmemRValid`  out  1  one-cycle pulse: `DmemRData` is valid.
- `DmemStall`  out  1  hold pipeline registers; the request inputs must stay stable while this is high.
- `DmemErr`  out  1  one-cycle pulse: the request was illegal and no access was performed.

## Operation

- **Request definition:** a request is `DmemREB==0 || DmemWEB==0`.
  - `REB` low, `WEB` high: read.
  - `WEB` low, `REB` high: write.
  - Both low: illegal.
- **Legality check**, evaluated at capture:
  - `DmemAddr[1:0]` must be 2'b00.
  - `DmemAddr[31:ADDR_W+2]` must be zero.
  - Exactly one of `REB`/`WEB` must be low.
  - Word index is `DmemAddr[ADDR_W+1:2]`.
- **State machine:** IDLE, BUSY, DONE.
  - **IDLE**
    - With a request: capture address, data, kind and the legality bit; load the down-counter with `WAIT_CYCLES`; go to BUSY.
    - `DmemStall` is driven combinationally high in the same cycle.
    - Without a request: stay in IDLE; `DmemStall` = 0.
  - **BUSY**
    - `DmemStall` = 1.
    - Counter ≠ 0: decrement and stay in BUSY.
    - Counter = 0, legal write: write the array.
    - Counter = 0, legal read: register the array word into `DmemRData`.
    - Counter = 0, illegal request: clear `DmemRData` to 0 and leave the array untouched.
    - After the counter-0 cycle, go to DONE.
  - **DONE**
    - `DmemStall` = 0.
    - Legal read: `DmemRValid` = 1.
    - Illegal request: `DmemErr` = 1.
    - Unconditionally return to IDLE. Request inputs seen in DONE are ignored, because they still belong to the instruction that advances at this edge.
- `DmemRData` holds its value until the next read or illegal completion; writes do not change it.
- Array contents are not reset and are undefined until written.

## Timing

- **Reset values:** state IDLE, counter 0, `DmemRData` 0, `DmemRValid` 0, `DmemErr` 0.
  - `DmemStall` is 0 while `rst_n` is low, even if a request is present.
- **Latency:** request first seen in IDLE at cycle T.
  - BUSY occupies cycles T+1 through T+1+`WAIT_CYCLES`.
  - The array access occurs on the rising edge that ends cycle T+1+`WAIT_CYCLES`.
  - DONE is cycle T+2+`WAIT_CYCLES`.
  - `DmemStall` is high for cycles T through T+1+`WAIT_CYCLES` (`WAIT_CYCLES`+2 cycles in total).
- **Back-to-back:** with a new request present at T+3+`WAIT_CYCLES` (IDLE), there is exactly one non-stalled cycle (DONE) between accesses.
- **Read-after-write** to the same word in consecutive accesses returns the new data. There is no bypass path; none is needed, because the write completes before DONE.
- **Reset mid-operation:** `rst_n` low during IDLE or BUSY aborts the access.
  - A write is committed only if the access edge occurred before reset was sampled low.
  - No `DmemRValid` or `DmemErr` pulse follows the abort.
- **Requests that change** while `DmemStall` is high are a protocol violation; the captured values are used.

## Test plan

- **Write then read, `WAIT_CYCLES`=2:**
  - Stimulus: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010.
  - Required: `DmemStall` high for 4 cycles each; read returns `DmemRData`=0xDEADBEEF with a `DmemRValid` pulse at T+4.
- **`WAIT_CYCLES`=0, back-to-back reads:**
  - Stimulus: reads of 0x0 and 0x4, previously written as 0x11111111 and 0x22222222.
  - Required: `DmemStall` pattern 1,1,0,1,1,0; data appears in order.
- **Misaligned read** of 0x0000_0006:
  - Required: `DmemErr` pulse in DONE, `DmemRData`=0, no `DmemRValid`, memory unchanged.
- **Both request lines low**, address 0x8, `DmemWData`=0x5A5A5A5A:
  - Required: `DmemErr` pulse; a following read of 0x8 returns the prior contents.
- **Out-of-range write**, `ADDR_W`=10, address 0x0000_1000:
  - Required: `DmemErr` pulse; word 0 is not corrupted.
- **Reset mid-access:**
  - Stimulus: `rst_n` low in the first BUSY cycle of a write of 0xCAFEF00D to 0x20.
  - Required: state IDLE, all outputs 0, and a later read of 0x20 does not return 0xCAFEF00D.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: word-organised synchronous array
// behind an active-low read/write request, with configurable wait states.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        DmemREB,
    input  logic        DmemWEB,
    input  logic [31:0] DmemAddr,
    input  logic [31:0] DmemWData,
    output logic [31:0] DmemRData,
    output logic        DmemRValid,
    output logic        DmemStall,
    output logic        DmemErr
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic              legal_q;
    logic              req;
    logic              legal;
    logic              access;

    logic [31:0] mem [DEPTH];

    assign req = !DmemREB || !DmemWEB;

    // Aligned, in range, and exactly one request line asserted.
    assign legal = (DmemAddr[1:0] == 2'b00)
                && ((DmemAddr >> (ADDR_W + 2)) == 32'd0)
                && (DmemREB != DmemWEB);

    assign access = (state == BUSY) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            DmemRData <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state   <= BUSY;
                        cnt     <= 4'(WAIT_CYCLES);
                        idx_q   <= DmemAddr[ADDR_W+1:2];
                        wdata_q <= DmemWData;
                        write_q <= DmemREB;
                        legal_q <= legal;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= DONE;
                        if (!legal_q) begin
                            DmemRData <= '0;
                        end else if (!write_q) begin
                            DmemRData <= mem[idx_q];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array is not reset; a reset sampled on the access edge cancels the write.
    always_ff @(posedge clk) begin
        if (rst_n && access && legal_q && write_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign DmemStall  = rst_n && ((state == BUSY) || ((state == IDLE) && req));
    assign DmemRValid = (state == DONE) && legal_q && !write_q;
    assign DmemErr    = (state == DONE) && !legal_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder: two instances
// (2 and 0 wait states) checked against a word-level reference memory.
module tb_dmem_responder;

    localparam int unsigned AW0 = 10;
    localparam int unsigned W0  = 2;
    localparam int unsigned AW1 = 6;
    localparam int unsigned W1  = 0;

    logic        clk;
    logic        rst_n;
    logic        reb    [2];
    logic        web    [2];
    logic [31:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [31:0] rdata  [2];
    logic        rvalid [2];
    logic        stall  [2];
    logic        err    [2];

    int n_cmp;
    int n_bad;

    logic [31:0] mem_m [int];
    logic [31:0] rd_m  [2];
    bit          rd_k  [2];

    dmem_responder #(.ADDR_W(AW0), .WAIT_CYCLES(W0)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .DmemREB(reb[0]), .DmemWEB(web[0]), .DmemAddr(addr[0]), .DmemWData(wdata[0]),
        .DmemRData(rdata[0]), .DmemRValid(rvalid[0]), .DmemStall(stall[0]), .DmemErr(err[0])
    );

    dmem_responder #(.ADDR_W(AW1), .WAIT_CYCLES(W1)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .DmemREB(reb[1]), .DmemWEB(web[1]), .DmemAddr(addr[1]), .DmemWData(wdata[1]),
        .DmemRData(rdata[1]), .DmemRValid(rvalid[1]), .DmemStall(stall[1]), .DmemErr(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned aw_of(input int d);
        return (d == 0) ? AW0 : AW1;
    endfunction

    function automatic int unsigned wait_of(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic bit is_legal(input int d, input logic r, input logic w, input logic [31:0] a);
        longint limit;
        limit = longint'(4) << aw_of(d);
        return (a % 4 == 0) && (longint'(a) < limit) && (r != w);
    endfunction

    // One complete access; checks stall length, completion strobes and load data.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
        bit   legal;
        bit   rd;
        int   key;
        int   n;
        legal = is_legal(d, r, w, a);
        rd    = !r && w;
        key   = d * 65536 + int'(a / 4);

        @(negedge clk);
        check("idle_stall",  32'(stall[d]),  32'd0);
        check("idle_rvalid", 32'(rvalid[d]), 32'd0);
        check("idle_err",    32'(err[d]),    32'd0);
        reb[d] = r; web[d] = w; addr[d] = a; wdata[d] = wd;

        n = 0;
        forever begin
            #1;
            if (!stall[d]) break;
            n++;
            if (n > 40) break;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), 32'(wait_of(d) + 2));

        if (legal && !rd) mem_m[key] = wd;
        if (legal && rd) begin
            rd_k[d] = mem_m.exists(key);
            if (rd_k[d]) rd_m[d] = mem_m[key];
        end
        if (!legal) begin
            rd_m[d] = '0;
            rd_k[d] = 1'b1;
        end

        check("done_rvalid", 32'(rvalid[d]), 32'(legal && rd));
        check("done_err",    32'(err[d]),    32'(!legal));
        if (rd_k[d]) check("rdata", rdata[d], rd_m[d]);
        reb[d] = 1'b1; web[d] = 1'b1;
    endtask

    initial begin
        int          d;
        int          k;
        int          m;
        int unsigned idx;
        logic        r;
        logic        w;
        logic [31:0] a;

        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 2; i++) begin
            reb[i] = 1'b1; web[i] = 1'b1; addr[i] = '0; wdata[i] = '0;
            rd_m[i] = '0; rd_k[i] = 1'b1;
        end

        // Reset with a request present: no stall, outputs quiet.
        rst_n = 1'b0;
        reb[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall",  32'(stall[0]),  32'd0);
        check("rst_rvalid", 32'(rvalid[0]), 32'd0);
        check("rst_err",    32'(err[0]),    32'd0);
        check("rst_rdata",  rdata[0],       32'd0);
        check("rst_rdata1", rdata[1],       32'd0);
        reb[0] = 1'b1;
        rst_n  = 1'b1;

        // Write then read with two wait states.
        access(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);

        // Zero wait states, back-to-back.
        access(1, 1'b1, 1'b0, 32'h0, 32'h1111_1111);
        access(1, 1'b1, 1'b0, 32'h4, 32'h2222_2222);
        access(1, 1'b0, 1'b1, 32'h0, 32'h0);
        access(1, 1'b0, 1'b1, 32'h4, 32'h0);

        // Illegal requests.
        access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0BAD_F00D);
        access(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0123_4567);
        access(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        access(0, 1'b0, 1'b1, 32'h0000_0006, 32'h0);
        access(0, 1'b0, 1'b0, 32'h0000_0008, 32'h5A5A_5A5A);
        access(0, 1'b0, 1'b1, 32'h0000_0008, 32'h0);
        access(0, 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF);
        access(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0);
        access(0, 1'b1, 1'b0, 32'h0000_0FFC, 32'h7777_8888);
        access(0, 1'b0, 1'b1, 32'h0000_0FFC, 32'h0);

        // Reset in the first BUSY cycle of a write aborts it.
        access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h1234_5678);
        @(negedge clk);
        reb[0] = 1'b1; web[0] = 1'b0; addr[0] = 32'h20; wdata[0] = 32'hCAFE_F00D;
        #1;
        check("abort_stall_T", 32'(stall[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_stall_rst", 32'(stall[0]), 32'd0);
        web[0] = 1'b1;
        @(negedge clk);
        #1;
        check("abort_stall",  32'(stall[0]),  32'd0);
        check("abort_rvalid", 32'(rvalid[0]), 32'd0);
        check("abort_err",    32'(err[0]),    32'd0);
        check("abort_rdata",  rdata[0],       32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rd_m[i] = '0;
            rd_k[i] = 1'b1;
        end
        repeat (2) @(negedge clk);
        check("abort_quiet_rvalid", 32'(rvalid[0]), 32'd0);
        check("abort_quiet_err",    32'(err[0]),    32'd0);
        access(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);

        // Randomized mix on both instances.
        for (int t = 0; t < 160; t++) begin
            d   = int'($urandom_range(0, 1));
            k   = int'($urandom_range(0, 9));
            m   = int'($urandom_range(0, 9));
            idx = $urandom_range(0, 15);
            r   = 1'b1;
            w   = 1'b1;
            if (k == 0) begin
                r = 1'b0; w = 1'b0;
            end else if (k < 5) begin
                w = 1'b0;
            end else begin
                r = 1'b0;
            end
            a = idx * 4;
            if (m == 0) a = a + $urandom_range(1, 3);
            if (m == 1) a = a + (32'd1 << (aw_of(d) + 2 + $urandom_range(0, 3)));
            access(d, r, w, a, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
